// File: rtl/fetch_pkg.sv
// Shared types, widths and branch-target arithmetic for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned INS_W = 32;
  localparam int unsigned PC_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD,
    ST_HALT
  } fetch_state_t;

  // pc4 plus the sign-extended word offset; wraps modulo 2^PC_W.
  function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0] pc4,
                                                     input logic [15:0]     imm16);
    return pc4 + {{(PC_W-18){imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundles the instruction-memory handshake and the decoder-facing ins/redirect signals.
interface instruction_fetch_if;
  import fetch_pkg::*;

  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_ready;
  logic [INS_W-1:0] imem_rdata;
  logic [INS_W-1:0] ins;
  logic             ins_valid;
  logic             ins_ready;
  logic [PC_W-1:0]  pc_out;
  logic             jump;
  logic             jumpReg;
  logic             branchTaken;
  logic [PC_W-1:0]  rs_value;
  logic             fault;

  modport master (
    output imem_req, imem_addr, ins, ins_valid, pc_out, fault,
    input  imem_ready, imem_rdata, ins_ready, jump, jumpReg, branchTaken, rs_value
  );

  modport slave (
    input  imem_req, imem_addr, ins, ins_valid, pc_out, fault,
    output imem_ready, imem_rdata, ins_ready, jump, jumpReg, branchTaken, rs_value
  );

endinterface

// File: rtl/instruction_fetch_next_pc_calc.sv
// Combinational next-PC selection: jumpReg, then jump, then taken branch, then pc+4.
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [PC_W-1:0] i_pc_out,
  input  logic [25:0]     i_ins_target,
  input  logic            i_jump,
  input  logic            i_jump_reg,
  input  logic            i_branch_taken,
  input  logic [PC_W-1:0] i_rs_value,
  output logic [PC_W-1:0] o_next_pc
);

  logic [PC_W-1:0] w_pc4;

  assign w_pc4 = i_pc_out + PC_W'(4);

  always_comb begin
    o_next_pc = w_pc4;
    if (i_jump_reg) begin
      o_next_pc = i_rs_value;
    end else if (i_jump) begin
      o_next_pc = {w_pc4[PC_W-1:PC_W-4], i_ins_target, 2'b00};
    end else if (i_branch_taken) begin
      o_next_pc = branch_target(w_pc4, i_ins_target[15:0]);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: owns the PC, fetches words over imem_req/imem_ready, presents ins.
// Optional FETCH_ALIGN_CHECK_EN: misaligned jumpReg targets raise sticky fault and halt.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset_n,
  instruction_fetch_if.master bus
);

  fetch_state_t     r_state;
  fetch_state_t     w_next_state;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  r_pc_out;
  logic [INS_W-1:0] r_ins;
  logic [PC_W-1:0]  w_next_pc;
  logic [PC_W-1:0]  w_rs_value;
  logic             w_misaligned;
  logic             w_capture;
  logic             w_consume;

  assign w_capture = (r_state == ST_FETCH) && bus.imem_ready;
  assign w_consume = (r_state == ST_HOLD) && bus.ins_ready;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_fault;

  assign w_rs_value   = bus.rs_value;
  assign w_misaligned = bus.jumpReg && (bus.rs_value[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fault <= 1'b0;
    end else if (w_consume && w_misaligned) begin
      r_fault <= 1'b1;
    end
  end

  assign bus.fault = r_fault;
`else
  // Low two bits are dropped so a jumpReg target is always word aligned.
  assign w_rs_value   = bus.rs_value & ~PC_W'(3);
  assign w_misaligned = 1'b0;
  assign bus.fault    = 1'b0;
`endif

  next_pc_calc u_next_pc_calc (
    .i_pc_out       (r_pc_out),
    .i_ins_target   (r_ins[25:0]),
    .i_jump         (bus.jump),
    .i_jump_reg     (bus.jumpReg),
    .i_branch_taken (bus.branchTaken),
    .i_rs_value     (w_rs_value),
    .o_next_pc      (w_next_pc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:  w_next_state = ST_FETCH;
      ST_FETCH: if (bus.imem_ready) w_next_state = ST_HOLD;
      ST_HOLD:  if (bus.ins_ready)  w_next_state = w_misaligned ? ST_HALT : ST_FETCH;
      ST_HALT:  w_next_state = ST_HALT;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc     <= RESET_PC;
      r_pc_out <= RESET_PC;
      r_ins    <= '0;
    end else begin
      if (w_capture) begin
        r_ins    <= bus.imem_rdata;
        r_pc_out <= r_pc;
      end
      if (w_consume && !w_misaligned) begin
        r_pc <= w_next_pc;
      end
    end
  end

  // Handshake flags decode straight from state, so reset drops them without waiting for an edge.
  assign bus.imem_req  = (r_state == ST_FETCH);
  assign bus.ins_valid = (r_state == ST_HOLD);
  assign bus.imem_addr = r_pc;
  assign bus.ins       = r_ins;
  assign bus.pc_out    = r_pc_out;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with RESET_PC = 32'h100.
module tb_instruction_fetch;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  instruction_fetch_if bus ();

  instruction_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.imem_ready  = 1'b0;
    bus.imem_rdata  = '0;
    bus.ins_ready   = 1'b0;
    bus.jump        = 1'b0;
    bus.jumpReg     = 1'b0;
    bus.branchTaken = 1'b0;
    bus.rs_value    = '0;
  endtask

  task automatic consume(input logic j, input logic jr, input logic br, input logic [31:0] rs);
    bus.ins_ready   = 1'b1;
    bus.jump        = j;
    bus.jumpReg     = jr;
    bus.branchTaken = br;
    bus.rs_value    = rs;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic fetch_word(input logic [31:0] w);
    bus.imem_ready = 1'b1;
    bus.imem_rdata = w;
    @(negedge clk);
    bus.imem_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_addr;
    idle_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    check_vec("rst_req",    32'(bus.imem_req),  32'h0);
    check_vec("rst_addr",   bus.imem_addr,      32'h100);
    check_vec("rst_ins",    bus.ins,            32'h0);
    check_vec("rst_valid",  32'(bus.ins_valid), 32'h0);
    check_vec("rst_pc_out", bus.pc_out,         32'h100);
    check_vec("rst_fault",  32'(bus.fault),     32'h0);

    reset_n = 1'b1;
    #1;
    check_vec("idle_req", 32'(bus.imem_req), 32'h0);
    @(negedge clk);

    // Zero-wait memory, ins_ready held high: FETCH/HOLD alternate every cycle.
    for (int k = 0; k < 6; k++) begin
      exp_addr = 32'h100 + 32'(4 * (k / 2));
      if ((k % 2) == 0) begin
        check_vec("zw_req",   32'(bus.imem_req),  32'h1);
        check_vec("zw_addr",  bus.imem_addr,      exp_addr);
        check_vec("zw_valid", 32'(bus.ins_valid), 32'h0);
      end else begin
        check_vec("zw_req",    32'(bus.imem_req),  32'h0);
        check_vec("zw_valid",  32'(bus.ins_valid), 32'h1);
        check_vec("zw_ins",    bus.ins,            32'hA000_0000 | exp_addr);
        check_vec("zw_pc_out", bus.pc_out,         exp_addr);
      end
      bus.imem_ready = 1'b1;
      bus.ins_ready  = 1'b1;
      bus.imem_rdata = 32'hA000_0000 | bus.imem_addr;
      if (k == 5) begin
        bus.imem_rdata = 32'hFFFF_FFFF;
        bus.ins_ready  = 1'b0;
      end
      @(negedge clk);
    end

    check_vec("hold_ign_ready_ins",   bus.ins,            32'hA000_0108);
    check_vec("hold_ign_ready_valid", 32'(bus.ins_valid), 32'h1);
    check_vec("hold_ign_ready_req",   32'(bus.imem_req),  32'h0);
    idle_inputs();

    consume(1'b0, 1'b0, 1'b0, 32'h0);
    check_vec("ws_req0",  32'(bus.imem_req), 32'h1);
    check_vec("ws_addr0", bus.imem_addr,     32'h10C);
    for (int k = 0; k < 3; k++) begin
      bus.imem_rdata = 32'hDEAD_0000 + 32'(k);
      bus.ins_ready  = 1'b1;
      @(negedge clk);
      bus.ins_ready  = 1'b0;
      check_vec("ws_req",   32'(bus.imem_req),  32'h1);
      check_vec("ws_addr",  bus.imem_addr,      32'h10C);
      check_vec("ws_valid", 32'(bus.ins_valid), 32'h0);
    end
    fetch_word(32'h1234_5678);
    check_vec("ws_ins",    bus.ins,            32'h1234_5678);
    check_vec("ws_valid1", 32'(bus.ins_valid), 32'h1);
    check_vec("ws_pc_out", bus.pc_out,         32'h10C);

    consume(1'b0, 1'b1, 1'b0, 32'h2000_0010);
    check_vec("jr_addr", bus.imem_addr, 32'h2000_0010);
    fetch_word(32'h0C00_0040);
    check_vec("j_pc_out", bus.pc_out, 32'h2000_0010);
    consume(1'b1, 1'b0, 1'b0, 32'h0);
    check_vec("j_addr", bus.imem_addr, 32'h2000_0100);

    fetch_word(32'h0);
    consume(1'b0, 1'b1, 1'b0, 32'h40);
    fetch_word(32'h1000_FFFF);
    consume(1'b0, 1'b0, 1'b1, 32'h0);
    check_vec("br_back_addr", bus.imem_addr, 32'h40);

    fetch_word(32'h0);
    consume(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
    check_vec("wrap_pre_addr", bus.imem_addr, 32'hFFFF_FFFC);
    fetch_word(32'h0);
    check_vec("wrap_pc_out", bus.pc_out, 32'hFFFF_FFFC);
    consume(1'b0, 1'b0, 1'b0, 32'h0);
    check_vec("wrap_addr", bus.imem_addr, 32'h0);

    fetch_word(32'h0C00_0040);
    consume(1'b1, 1'b0, 1'b1, 32'h0);
    check_vec("j_over_br_addr", bus.imem_addr, 32'h100);

    fetch_word(32'h0C00_0040);
    consume(1'b1, 1'b1, 1'b0, 32'h302);
`ifdef FETCH_ALIGN_CHECK_EN
    check_vec("mis_fault", 32'(bus.fault),     32'h1);
    check_vec("mis_req",   32'(bus.imem_req),  32'h0);
    check_vec("mis_valid", 32'(bus.ins_valid), 32'h0);
    check_vec("mis_addr",  bus.imem_addr,      32'h100);
    bus.imem_ready = 1'b1;
    bus.ins_ready  = 1'b1;
    repeat (3) @(negedge clk);
    idle_inputs();
    check_vec("halt_req",   32'(bus.imem_req),  32'h0);
    check_vec("halt_valid", 32'(bus.ins_valid), 32'h0);
    check_vec("halt_fault", 32'(bus.fault),     32'h1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_vec("halt_exit_fault", 32'(bus.fault), 32'h0);
    check_vec("halt_exit_addr",  bus.imem_addr,  32'h100);
    fetch_word(32'h5555_AAAA);
`else
    check_vec("jr_jump_addr",  bus.imem_addr,     32'h300);
    check_vec("jr_jump_req",   32'(bus.imem_req), 32'h1);
    check_vec("jr_jump_fault", 32'(bus.fault),    32'h0);
    fetch_word(32'h5555_AAAA);
    check_vec("jr_jump_pc_out", bus.pc_out, 32'h300);
`endif

    check_vec("hold_valid", 32'(bus.ins_valid), 32'h1);
    check_vec("hold_ins",   bus.ins,            32'h5555_AAAA);
    bus.imem_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    check_vec("arst_valid",  32'(bus.ins_valid), 32'h0);
    check_vec("arst_req",    32'(bus.imem_req),  32'h0);
    check_vec("arst_ins",    bus.ins,            32'h0);
    check_vec("arst_pc_out", bus.pc_out,         32'h100);
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b1;
    #1;
    check_vec("rel_req",  32'(bus.imem_req), 32'h0);
    check_vec("rel_addr", bus.imem_addr,     32'h100);
    @(negedge clk);
    check_vec("refetch_req",  32'(bus.imem_req), 32'h1);
    check_vec("refetch_addr", bus.imem_addr,     32'h100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
